// File: rtl/dcp_utlb_if.sv
// Requester/walker bundle for the dcp_utlb micro-TLB.
`ifndef DCP_VADDR
`define DCP_VADDR 32
`endif

interface dcp_utlb_if #(
  parameter int NUM_CH = 2,
  parameter int VPN_W  = `DCP_VADDR-12
);
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*VPN_W-1:0] req_vpn;
  logic [NUM_CH-1:0]       req_ack;
  logic [VPN_W-1:0]        req_ppn;
  logic                    miss_valid;
  logic [VPN_W-1:0]        miss_vpn;
  logic                    miss_ack;
  logic [VPN_W-1:0]        miss_ppn;
  logic                    flush;
  logic                    busy;

  modport master (
    output req_valid, req_vpn,
    output miss_ack, miss_ppn, flush,
    input  req_ack, req_ppn,
    input  miss_valid, miss_vpn, busy
  );

  modport slave (
    input  req_valid, req_vpn,
    input  miss_ack, miss_ppn, flush,
    output req_ack, req_ppn,
    output miss_valid, miss_vpn, busy
  );
endinterface

// File: rtl/dcp_utlb.sv
// Shared micro-TLB: round-robin requesters, fully
// associative FIFO-replaced entries, one walk at a time.
`ifndef DCP_VADDR
`define DCP_VADDR 32
`endif

module dcp_utlb #(
  parameter int NUM_CH  = 2,
  parameter int ENTRIES = 4,
  parameter int VPN_W   = `DCP_VADDR-12
) (
  input  logic       clk,
  input  logic       rst,
  dcp_utlb_if.slave  bus
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE, LOOKUP, MISS, RESP
  } state_e;

  state_e            state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     last_q;
  logic [VPN_W-1:0]  vpn_q;
  logic [VPN_W-1:0]  ppn_q;
  logic [NUM_CH-1:0] ack_q;
  logic              mv_q;
  logic              busy_q;
  logic [EW-1:0]     fill_q;
  logic [ENTRIES-1:0] ev_q;
  logic [VPN_W-1:0]  evpn_q [ENTRIES];
  logic [VPN_W-1:0]  eppn_q [ENTRIES];

  logic              gnt_any;
  logic [GW-1:0]     gnt_idx;
  logic [VPN_W-1:0]  gnt_vpn;
  logic              hit;
  logic [VPN_W-1:0]  hit_ppn;

  // Distance 0 is the channel right after the last grant.
  always_comb begin
    int d;
    int best;
    gnt_any = |bus.req_valid;
    gnt_idx = '0;
    gnt_vpn = '0;
    best    = NUM_CH;
    d       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      d = (i + NUM_CH - 1 - int'(last_q)) % NUM_CH;
      if (bus.req_valid[i] && d < best) begin
        best    = d;
        gnt_idx = GW'(i);
        gnt_vpn = bus.req_vpn[i*VPN_W +: VPN_W];
      end
    end
  end

  // Scan downward so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int e = ENTRIES-1; e >= 0; e--) begin
      if (ev_q[e] && evpn_q[e] == vpn_q) begin
        hit     = 1'b1;
        hit_ppn = eppn_q[e];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_CH-1);
      vpn_q   <= '0;
      ppn_q   <= '0;
      ack_q   <= '0;
      mv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fill_q  <= '0;
      ev_q    <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        evpn_q[e] <= '0;
        eppn_q[e] <= '0;
      end
    end else begin
      ack_q <= '0;
      if (bus.flush) ev_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            grant_q <= gnt_idx;
            vpn_q   <= gnt_vpn;
            busy_q  <= 1'b1;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit && !bus.flush) begin
            ppn_q   <= hit_ppn;
            ack_q   <= NUM_CH'(1) << grant_q;
            state_q <= RESP;
          end else begin
            mv_q    <= 1'b1;
            state_q <= MISS;
          end
        end
        MISS: begin
          if (bus.miss_ack) begin
            ppn_q   <= bus.miss_ppn;
            ack_q   <= NUM_CH'(1) << grant_q;
            mv_q    <= 1'b0;
            state_q <= RESP;
            if (!bus.flush) begin
              ev_q[fill_q]   <= 1'b1;
              evpn_q[fill_q] <= vpn_q;
              eppn_q[fill_q] <= bus.miss_ppn;
              fill_q <= (fill_q == EW'(ENTRIES-1))
                        ? '0 : fill_q + 1'b1;
            end
          end
        end
        RESP: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ack    = ack_q;
  assign bus.req_ppn    = ppn_q;
  assign bus.miss_valid = mv_q;
  assign bus.miss_vpn   = vpn_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/dcp_utlb.md
DCP_UTLB -- requirements
Module: dcp_utlb

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels, range 1..8.
REQ-002 Parameter ENTRIES, default 4: number of fully associative translation entries, range 1..16.
REQ-003 Parameter VPN_W, default `DCP_VADDR-12: VPN/PPN width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NUM_CH  per-channel request; the master holds it until acked.
REQ-007 req_vpn  in  NUM_CH*VPN_W  channel i VPN at bits [i*VPN_W +: VPN_W]; held while req_valid is high.
REQ-008 req_ack  out  NUM_CH  one-cycle pulse to the served channel.
REQ-009 req_ppn  out  VPN_W  translation, shared by all channels; valid in the cycle req_ack is high.
REQ-010 miss_valid  out  1  downstream walk request, held until miss_ack.
REQ-011 miss_vpn  out  VPN_W  VPN of the walk; stable while miss_valid is high.
REQ-012 miss_ack  in  1  one-cycle downstream completion.
REQ-013 miss_ppn  in  VPN_W  walk result, sampled when miss_ack is high.
REQ-014 flush  in  1  invalidates all entries.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LOOKUP, MISS and RESP, one request in flight at a time.
REQ-017 IDLE: if any req_valid is high, grant round-robin starting at channel (last_grant+1) mod NUM_CH, latch the grant index and its VPN, then go to LOOKUP; otherwise stay in IDLE.
REQ-018 LOOKUP: compare the latched VPN against all valid entries.
  - Hit: latch that entry's PPN, go to RESP.
  - Miss: go to MISS.
REQ-019 MISS: miss_valid=1 and miss_vpn=latched VPN; on miss_ack, latch miss_ppn, write {valid, VPN, PPN} into the entry at the fill pointer, advance the pointer, go to RESP.
REQ-020 The fill pointer SHALL advance FIFO-style and wrap from ENTRIES-1 to 0.
REQ-021 RESP: pulse req_ack[grant] for exactly one cycle with req_ppn driven, set last_grant=grant, return to IDLE.
REQ-022 Latency, with request sampled in IDLE at cycle T:
  - Hit: ack at T+2.
  - Miss: miss_valid at T+2; ack one cycle after the miss_ack cycle.
REQ-023 req_ppn SHALL hold its last value between acks.
REQ-024 req_ack SHALL be 0 for all channels outside RESP.
REQ-025 At most one req_ack bit is high in any cycle.
REQ-026 miss_ack outside MISS SHALL be ignored.
REQ-027 Flush clears all valid bits at the next edge; the fill pointer is unchanged.
REQ-028 Flush in LOOKUP SHALL force a miss.
REQ-029 Flush coinciding with miss_ack:
  - The flush wins and no entry is written.
  - The response is still delivered with miss_ppn.
REQ-030 Flush SHALL NOT abort an in-flight request.
REQ-031 If multiple entries match, the lowest-index match is used.
  - This is unreachable in normal operation, because only misses fill.

Reset
REQ-032 On rst the FSM SHALL go to IDLE asynchronously, including from MISS mid-walk.
REQ-033 Reset values: req_ack=0, miss_valid=0, busy=0, req_ppn=0, miss_vpn=0, all valid bits=0, fill pointer=0, last_grant=NUM_CH-1 so that channel 0 has first priority.
REQ-034 A miss_ack arriving after reset SHALL be ignored.

Verification
REQ-035 Cold miss: ch0 VPN 0x123.
  - Cycle 2: miss_valid=1, miss_vpn=0x123.
  - miss_ack with miss_ppn 0x456 -> req_ack[0] next cycle, req_ppn=0x456.
REQ-036 Hit: repeat ch0 VPN 0x123 -> req_ack[0] at T+2, req_ppn=0x456, miss_valid stays 0.
REQ-037 Round-robin: ch0 and ch1 held valid continuously with distinct cached VPNs -> acks alternate 0,1,0,1, with no starvation.
REQ-038 Wrap/evict: ENTRIES=4, fill VPNs 1..5 -> VPN 1 misses again; VPNs 2..5 hit.
REQ-039 Flush with fill: flush in the miss_ack cycle for VPN 0x7 -> ack delivered, then VPN 0x7 misses again; a flush in IDLE makes a prior hit VPN miss.
REQ-040 Reset during MISS -> miss_valid=0 immediately, busy=0; a later miss_ack produces no req_ack.
